fnd_scan_cntr: RTL and testbench

//  Time-multiplexed driver for a 4-digit common-anode 7-segment (FND) display.

---
 rtl/fnd_scan_cntr.sv | 128 ++++++++++++
 tb/tb_fnd_scan_cntr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_cntr.sv
// rtl/fnd_scan_cntr.sv - scanned 4-digit common-anode 7-segment display driver
//
// Scans one digit every CLK_DIV clocks. Each digit's nibble is taken from a
// frame-latched copy of value, decoded to segments, and its common line is
// pulled low. value/dp_in are sampled only at the start of a frame, so updates
// mid-frame never tear the display.
//
// Optional feature macro: FND_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits 3..1 are blanked (a..g off). The decimal
//   point still follows dp_in, and digit 0 is never blanked.
//
// Ports:
//   clk         in   1    system clock, rising edge
//   reset_p     in   1    asynchronous active-high reset
//   value       in   16   display value, [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   dp_in       in   4    decimal point per digit, 1=lit
//   seg_7       out  8    segments, active-low, {dp,g,f,e,d,c,b,a}
//   com         out  4    digit commons, active-low, bit n -> digit n
//   frame_tick  out  1    one-cycle pulse when a new frame starts (value latched)

module fnd_scan_cntr #(
    parameter int CLK_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [7:0]  seg_7,
    output logic [3:0]  com,
    output logic        frame_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   lat_value;
    logic [3:0]    lat_dp;

    logic          slot_tick;
    logic          frame_start;
    logic [1:0]    next_idx;
    logic [15:0]   next_value;
    logic [3:0]    next_dp;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_on;
    logic [7:0]    next_seg;
    logic [3:0]    next_com;

    // Active-high segment shapes, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_tick   = (cnt == CNT_LAST);
        frame_start = slot_tick && (idx == 2'd3);
        next_idx    = idx + 2'd1;

        // The digit-0 outputs are computed on the same edge that latches the
        // new frame, so they must see the incoming value, not the old latch.
        next_value  = frame_start ? value : lat_value;
        next_dp     = frame_start ? dp_in : lat_dp;
        nib         = next_value[{next_idx, 2'b00} +: 4];

`ifdef FND_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit to its left are 0.
        case (next_idx)
            2'd3:    blank = (next_value[15:12] == 4'h0);
            2'd2:    blank = (next_value[15:8]  == 8'h00);
            2'd1:    blank = (next_value[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        seg_on   = blank ? 7'h00 : decode(nib);
        next_seg = {~next_dp[next_idx], ~seg_on};
        next_com = ~(4'b0001 << next_idx);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt        <= '0;
            idx        <= 2'd3;
            lat_value  <= 16'h0000;
            lat_dp     <= 4'h0;
            seg_7      <= 8'hFF;
            com        <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= slot_tick ? '0 : cnt + 1'b1;
            frame_tick <= frame_start;
            if (slot_tick) begin
                idx   <= next_idx;
                seg_7 <= next_seg;
                com   <= next_com;
            end
            if (frame_start) begin
                lat_value <= value;
                lat_dp    <= dp_in;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_cntr.sv
// tb/tb_fnd_scan_cntr.sv - self-checking bench for fnd_scan_cntr

module tb_fnd_scan_cntr;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [7:0]  seg_7;
    logic [3:0]  com;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail   = 0;

    fnd_scan_cntr #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .value      (value),
        .dp_in      (dp_in),
        .seg_7      (seg_7),
        .com        (com),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Active-high shapes {g..a} for hex digits 0..F.
    logic [6:0] shape [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k = rising edges since reset release. Slot s = k/DIV; slot 0 is
    // dark, slot s>=1 shows digit (s-1)%4. Frames start at slots 1,5,9,...
    int          k;
    logic [15:0] m_val;
    logic [3:0]  m_dp;

    always @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            k     = 0;
            m_val = 16'h0;
            m_dp  = 4'h0;
        end else begin
            k = k + 1;
            if (k % DIV == 0 && ((k / DIV - 1) % 4) == 0) begin
                m_val = value;
                m_dp  = dp_in;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_seg;
        logic [3:0] e_com;
        logic       e_ft;
        int         d;
        logic       blank;
        if (reset_p || k < DIV) begin
            e_seg = 8'hFF;
            e_com = 4'hF;
            e_ft  = 1'b0;
        end else begin
            d     = (k / DIV - 1) % 4;
            e_com = 4'hF & ~(4'b0001 << d);
            e_ft  = (k % DIV == 0) && (d == 0);
`ifdef FND_LEADING_ZERO_BLANK_EN
            blank = (d > 0) && ((m_val >> (4 * d)) == 16'h0);
`else
            blank = 1'b0;
`endif
            e_seg = {~m_dp[d], blank ? 7'h7F : ~shape[(m_val >> (4 * d)) & 16'hF]};
        end
        chk("model_seg_7", {24'h0, seg_7}, {24'h0, e_seg});
        chk("model_com", {28'h0, com}, {28'h0, e_com});
        chk("model_frame_tick", {31'h0, frame_tick}, {31'h0, e_ft});
    end

    task automatic wait_com(input logic [3:0] c);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (com == c) found = 1'b1;
        end
        chk("wait_com_timeout", {31'h0, found}, 32'h1);
    endtask

    logic [7:0] lit_seg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [3:0] lit_com [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        reset_p = 1'b1;
        value   = 16'h1234;
        dp_in   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", {24'h0, seg_7}, 32'hFF);
        chk("reset_com", {28'h0, com}, 32'hF);
        chk("reset_ft", {31'h0, frame_tick}, 32'h0);

        // Scenarios 1/2: release, first frame of 1234
        @(negedge clk);
        reset_p = 1'b0;
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        chk("first_ft", {31'h0, frame_tick}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                repeat (DIV) @(posedge clk);
                @(negedge clk);
            end
            chk("f1234_com", {28'h0, com}, {28'h0, lit_com[i]});
            chk("f1234_seg", {24'h0, seg_7}, {24'h0, lit_seg[i]});
        end

        // Scenario 3: change value during digit 1 of the next frame
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        chk("f2_d0_seg", {24'h0, seg_7}, 32'h99);
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        value = 16'hABCD;
        chk("f2_d1_seg", {24'h0, seg_7}, 32'hB0);
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        chk("tear_d2_seg", {24'h0, seg_7}, 32'hA4);
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        chk("tear_d3_seg", {24'h0, seg_7}, 32'hF9);
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        chk("abcd_ft", {31'h0, frame_tick}, 32'h1);
        chk("abcd_d0_seg", {24'h0, seg_7}, 32'hA1);

        // Scenario 4: decimal point on digit 2, value 0
        value = 16'h0000;
        dp_in = 4'b0100;
        repeat (4 * DIV) @(posedge clk);
        wait_com(4'b1011);
`ifdef FND_LEADING_ZERO_BLANK_EN
        chk("dp_d2_seg", {24'h0, seg_7}, 32'h7F);
`else
        chk("dp_d2_seg", {24'h0, seg_7}, 32'h40);
`endif
        wait_com(4'b1110);
        chk("dp_d0_seg", {24'h0, seg_7}, 32'hC0);

        // Scenario 6: leading zeros
        value = 16'h0005;
        dp_in = 4'h0;
        repeat (4 * DIV) @(posedge clk);
        wait_com(4'b0111);
`ifdef FND_LEADING_ZERO_BLANK_EN
        chk("lz_d3_seg", {24'h0, seg_7}, 32'hFF);
`else
        chk("lz_d3_seg", {24'h0, seg_7}, 32'hC0);
`endif
        wait_com(4'b1110);
        chk("lz_d0_seg", {24'h0, seg_7}, 32'h92);

        // Scenario 5: asynchronous reset in the middle of digit 2
        wait_com(4'b1011);
        @(posedge clk);
        #1 reset_p = 1'b1;
        #1;
        chk("async_seg", {24'h0, seg_7}, 32'hFF);
        chk("async_com", {28'h0, com}, 32'hF);
        chk("async_ft", {31'h0, frame_tick}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        repeat (DIV - 1) @(posedge clk);
        @(negedge clk);
        chk("restart_dark_com", {28'h0, com}, 32'hF);
        @(posedge clk);
        @(negedge clk);
        chk("restart_com", {28'h0, com}, 32'hE);
        chk("restart_ft", {31'h0, frame_tick}, 32'h1);
        chk("restart_seg", {24'h0, seg_7}, 32'h92);

        repeat (8 * DIV) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
